// File: rtl/dmem_con_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_con_sequencer_if
// Brief    : BLOCKMEM console port plus tx/rx byte links of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_con_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [3:0]        con_write;
  logic [ADDR_W-1:0] con_addr;
  logic [31:0]       con_in;
  logic [31:0]       con_out;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output con_write, con_addr, con_in,
    input  con_out,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );

  modport slave (
    input  con_write, con_addr, con_in,
    output con_out,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/dmem_con_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_con_sequencer
// Brief    : Halts the core, then dumps or loads a data-memory word range over
//            a byte link. Optional DMEM_CON_SEQ_DUMP_CSUM_EN appends a 32-bit sum
//            of the dumped words.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_con_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1,
  parameter int HALT_TIMEOUT = 255
) (
  input  wire                  CLK,
  input  wire                  nrst,
  input  wire                  start,
  input  wire                  mode,
  input  wire [ADDR_W-1:0]     base_addr,
  input  wire [ADDR_W-1:0]     last_addr,
  output logic                 halt_req,
  input  wire                  halt_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  dmem_con_sequencer_if.master bus
);

  localparam int c_CNT_MAX = (HALT_TIMEOUT > RD_LAT) ? HALT_TIMEOUT : RD_LAT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_RD   = 3'd2,
    S_TX   = 3'd3,
    S_LD   = 3'd4,
    S_WR   = 3'd5,
    S_FIN  = 3'd6
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
    , S_CSUM = 3'd7
`endif
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_last;
  logic                r_mode;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [1:0]          r_byte;
  logic [31:0]         r_sh;
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
  logic [31:0]         r_sum;
`endif

  logic w_tx_take;
  logic w_rx_take;
  logic w_at_last;

  assign w_tx_take = bus.tx_valid && bus.tx_ready;
  assign w_rx_take = bus.rx_valid && bus.rx_ready;
  assign w_at_last = (bus.con_addr == r_last);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_last        <= '0;
      r_mode        <= 1'b0;
      r_cnt         <= '0;
      r_byte        <= '0;
      r_sh          <= '0;
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
      r_sum         <= '0;
`endif
      halt_req      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus.con_write <= '0;
      bus.con_addr  <= '0;
      bus.con_in    <= '0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      bus.rx_ready  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (last_addr < base_addr) begin
              error <= 1'b1;
            end else begin
              r_base   <= base_addr;
              r_last   <= last_addr;
              r_mode   <= mode;
              r_cnt    <= '0;
              halt_req <= 1'b1;
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
              r_sum    <= '0;
`endif
              r_state  <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (halt_ack) begin
            bus.con_addr <= r_base;
            r_cnt        <= '0;
            r_byte       <= '0;
            if (r_mode) begin
              bus.rx_ready <= 1'b1;
              r_state      <= S_LD;
            end else begin
              r_state      <= S_RD;
            end
          end else if (r_cnt == c_CNT_W'(HALT_TIMEOUT - 1)) begin
            halt_req <= 1'b0;
            error    <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD: begin
          // con_out is trusted only once the address has been held RD_LAT edges
          if (r_cnt == c_CNT_W'(RD_LAT)) begin
            r_sh         <= bus.con_out;
            bus.tx_data  <= bus.con_out[7:0];
            bus.tx_valid <= 1'b1;
            r_byte       <= '0;
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
            r_sum        <= r_sum + bus.con_out;
`endif
            r_state      <= S_TX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TX: begin
          if (w_tx_take) begin
            r_byte      <= r_byte + 2'd1;
            r_sh        <= r_sh >> 8;
            bus.tx_data <= r_sh[15:8];
            if (r_byte == 2'd3) begin
              bus.tx_valid <= 1'b0;
              if (!w_at_last) begin
                bus.con_addr <= bus.con_addr + 1'b1;
                r_cnt        <= '0;
                r_state      <= S_RD;
              end else begin
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
                r_sh         <= r_sum;
                bus.tx_data  <= r_sum[7:0];
                bus.tx_valid <= 1'b1;
                r_state      <= S_CSUM;
`else
                r_state      <= S_FIN;
`endif
              end
            end
          end
        end
`ifdef DMEM_CON_SEQ_DUMP_CSUM_EN
        S_CSUM: begin
          if (w_tx_take) begin
            r_byte      <= r_byte + 2'd1;
            r_sh        <= r_sh >> 8;
            bus.tx_data <= r_sh[15:8];
            if (r_byte == 2'd3) begin
              bus.tx_valid <= 1'b0;
              r_state      <= S_FIN;
            end
          end
        end
`endif
        S_LD: begin
          if (w_rx_take) begin
            bus.con_in <= {bus.rx_data, bus.con_in[31:8]};
            r_byte     <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              bus.rx_ready  <= 1'b0;
              bus.con_write <= 4'hF;
              r_state       <= S_WR;
            end
          end
        end
        S_WR: begin
          bus.con_write <= '0;
          if (w_at_last) begin
            r_state <= S_FIN;
          end else begin
            bus.con_addr <= bus.con_addr + 1'b1;
            bus.rx_ready <= 1'b1;
            r_state      <= S_LD;
          end
        end
        S_FIN: begin
          halt_req <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_con_sequencer.md
Name: dmem_con_sequencer

Overview:
- Controller that owns the core's data-memory console port (con_write/con_addr/con_in/con_out).
- On command it halts the core, then does one of two jobs over a word range:
  - dumps the words as a byte stream, or
  - loads words from a byte stream.
- Sits between the core's BLOCKMEM console port and a UART-style byte link. It lets memory be inspected or preloaded on the board the same way the bench checks it against the answer key.

Parameters:
- ADDR_W, 10, word-address width of the con_addr port (1024 words).
- RD_LAT, 1, cycles from con_addr valid to con_out valid (BLOCKMEM synchronous read).
- HALT_TIMEOUT, 255, cycles to wait for halt_ack before aborting with error.

Ports:
- CLK  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = dump, 1 = load.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- last_addr  in  ADDR_W  last word address, inclusive; latched on accepted start.
- halt_req  out  1  asks the core to freeze.
- halt_ack  in  1  core frozen; memory port free.
- con_write  out  4  byte-write enables to BLOCKMEM.
- con_addr  out  ADDR_W  word address to BLOCKMEM.
- con_in  out  32  write data to BLOCKMEM.
- con_out  in  32  read data from BLOCKMEM.
- tx_data  out  8  dump byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready.
- rx_data  in  8  load byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts byte when rx_valid & rx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse on rejected range or halt timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-operation aborts immediately, drops halt_req, and issues no write. Reset is asynchronous on nrst low.
- IDLE:
  - start=1 with last_addr < base_addr: pulse error next cycle, stay IDLE, no halt_req.
  - start=1 otherwise: latch addresses and mode, assert halt_req, go to HALT.
  - start while busy is ignored.
- HALT:
  - Wait for halt_ack while counting cycles.
  - If the count reaches HALT_TIMEOUT without ack: drop halt_req, pulse error, go to IDLE.
  - On ack: con_addr = base; go to RD if mode=0, LD if mode=1.
- RD:
  - Hold con_addr and wait RD_LAT cycles.
  - Capture con_out into a 32-bit shift register, then go to TX.
- TX:
  - Send 4 bytes, LSB first. tx_valid holds high with stable tx_data until tx_ready.
  - tx_valid may assert back-to-back across bytes.
  - After byte 3: if con_addr == last, go to FIN; else con_addr+1 and go to RD.
- LD:
  - rx_ready=1; collect 4 bytes LSB first into con_in.
  - rx_ready drops the cycle after byte 3 is taken; go to WR.
- WR:
  - con_write=4'hF for exactly one cycle with stable con_addr/con_in; con_write is 0 in all other states.
  - Then FIN if con_addr == last, else con_addr+1 and back to LD.
- FIN: drop halt_req, pulse done, go to IDLE (unless DUMP_CSUM_EN applies).
- Boundaries:
  - base == last transfers exactly one word.
  - last = 2^ADDR_W-1 ends without con_addr wrapping; con_addr never exceeds last.
  - halt_ack deasserting mid-transfer is ignored; halt_req stays asserted until FIN.
- Throughput: dump with tx_ready tied high = 1 + RD_LAT + 4 cycles per word.

Optional Feature:
- Macro DMEM_CON_SEQ_DUMP_CSUM_EN.
- Defined:
  - Dump keeps a 32-bit wrap-around sum of all words read, cleared on accepted start.
  - After the last word, state CSUM sends the sum as 4 more bytes, LSB first, with the same tx handshake, then FIN.
  - Load ignores the feature.
- Undefined: no sum register and no CSUM state; dump goes straight to FIN after the last word.

Test Plan:
- Dump: memory words 0x10-0x12 = 0x11223344, 0xA5A5A5A5, 0x00000001; start mode=0 base=0x10 last=0x12, halt_ack after 3 cycles, tx_ready=1.
  - Required bytes: 44 33 22 11 A5 A5 A5 A5 01 00 00 00, then one done pulse and halt_req low.
- Load: mode=1 base=0x3FE last=0x3FF; rx bytes EF BE AD DE 78 56 34 12.
  - Required: two one-cycle writes, 0xDEADBEEF@0x3FE and 0x12345678@0x3FF; no access at 0x000; done pulse.
- Bad range: start base=5 last=4.
  - Required: error pulse 1 cycle later; halt_req, busy, con_write stay 0.
- Halt timeout: halt_ack held 0.
  - Required: error pulse after 255 cycles in HALT; halt_req low; IDLE.
- Backpressure: dump of 1 word 0xCAFEF00D with tx_ready toggling every other cycle.
  - Required: bytes 0D F0 FE CA, tx_data stable while tx_valid & !tx_ready.
  - With the macro defined: also 0D F0 FE CA as the checksum.
- Reset: nrst low during WR of a load.
  - Required: con_write 0 at once; all outputs 0; next start accepted normally.
